// File: rtl/led_pwm_regs_if.sv
// rtl/led_pwm_regs_if.sv - local register bus between the AXI4-Lite slave and led_pwm_regs
interface led_pwm_regs_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] local_addr;
    logic [31:0]       local_wr_data;
    logic              local_wr;
    logic [31:0]       local_rd_data;

    modport master (
        output local_addr,
        output local_wr_data,
        output local_wr,
        input  local_rd_data
    );

    modport slave (
        input  local_addr,
        input  local_wr_data,
        input  local_wr,
        output local_rd_data
    );
endinterface

// File: rtl/led_pwm_regs.sv
// rtl/led_pwm_regs.sv - LED PWM register bank, prescaler, period counter and wrap interrupt
module led_pwm_regs #(
    parameter int N_CH   = 8,
    parameter int PWM_W  = 16,
    parameter int ADDR_W = 13
) (
    input  logic            axi_clk,
    input  logic            axi_rst,
    led_pwm_regs_if.slave   bus,
    output logic [N_CH-1:0] led_out,
    output logic            irq
);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_PERIOD   = IDX_W'(3);

    logic             en;
    logic             inv;
    logic             irq_en;
    logic             wrap_sts;
    logic [15:0]      prescale;
    logic [15:0]      pc;
    logic [PWM_W-1:0] period;
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty   [N_CH];
    logic [PWM_W-1:0] shadow [N_CH];

    logic [IDX_W-1:0] word_idx;
    logic [N_CH-1:0]  duty_hit;
    logic             tick;
    logic             cnt_at_top;
    logic             wrap_evt;
    logic             status_clr;
    logic [31:0]      rd_next;
    logic             unused_bits;

    assign unused_bits = ^{bus.local_wr_data, bus.local_addr[1:0]};

    always_comb begin
        word_idx = bus.local_addr[ADDR_W-1:2];
        for (int n = 0; n < N_CH; n++) begin
            duty_hit[n] = (word_idx == IDX_W'(4 + n));
        end
    end

    // A PERIOD written below cnt lets cnt run to all-ones, which is also treated as a wrap.
    always_comb begin
        tick       = en && (pc == prescale);
        cnt_at_top = (cnt == period) || (cnt == {PWM_W{1'b1}});
        wrap_evt   = tick && cnt_at_top;
        status_clr = bus.local_wr && (word_idx == IDX_STATUS) && bus.local_wr_data[0];
    end

    always_comb begin
        rd_next = '0;
        case (word_idx)
            IDX_CTRL:     rd_next = {29'd0, irq_en, inv, en};
            IDX_STATUS:   rd_next = {16'd0, 8'(N_CH), 7'd0, wrap_sts};
            IDX_PRESCALE: rd_next = {16'd0, prescale};
            IDX_PERIOD:   rd_next = 32'(period);
            default:      rd_next = '0;
        endcase
        for (int n = 0; n < N_CH; n++) begin
            if (duty_hit[n]) begin
                rd_next = 32'(duty[n]);
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            en                <= 1'b0;
            inv               <= 1'b0;
            irq_en            <= 1'b0;
            wrap_sts          <= 1'b0;
            prescale          <= '0;
            period            <= PWM_W'(255);
            pc                <= '0;
            cnt               <= '0;
            led_out           <= '0;
            irq               <= 1'b0;
            bus.local_rd_data <= '0;
            for (int n = 0; n < N_CH; n++) begin
                duty[n]   <= '0;
                shadow[n] <= '0;
            end
        end else begin
            bus.local_rd_data <= rd_next;

            if (bus.local_wr) begin
                case (word_idx)
                    IDX_CTRL:     {irq_en, inv, en} <= bus.local_wr_data[2:0];
                    IDX_PRESCALE: prescale          <= bus.local_wr_data[15:0];
                    IDX_PERIOD:   period            <= bus.local_wr_data[PWM_W-1:0];
                    default:      ;
                endcase
            end

            // A wrap on the same cycle as a W1C keeps the sticky bit set.
            if (wrap_evt) begin
                wrap_sts <= 1'b1;
            end else if (status_clr) begin
                wrap_sts <= 1'b0;
            end

            if (!en || tick) begin
                pc <= '0;
            end else begin
                pc <= pc + 16'd1;
            end

            if (!en || wrap_evt) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + PWM_W'(1);
            end

            for (int n = 0; n < N_CH; n++) begin
                if (bus.local_wr && duty_hit[n]) begin
                    duty[n] <= bus.local_wr_data[PWM_W-1:0];
                end
                if (!en || wrap_evt) begin
                    shadow[n] <= duty[n];
                end
                led_out[n] <= en ? ((cnt < shadow[n]) ^ inv) : inv;
            end

            irq <= wrap_sts & irq_en;
        end
    end
endmodule
